// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 64-bit timer/compare slave.
// A prescaled free-running mtime is compared against mtimecmp; a match
// latches status.pending, which drives irq when ctrl.irq_en is set.
// Register map (offset from BASE_ADDR):
//   0x00 mtime, 0x08 mtimecmp, 0x10 ctrl {auto_reload, irq_en, enable},
//   0x18 status {pending} (write 1 to clear), 0x20 prescale.
module bus_timer #(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_2000_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr,
    input  logic [2:0]  rd_ctrl,
    input  logic [2:0]  wr_ctrl,
    input  logic [63:0] data_in,
    output logic [63:0] data_out,
    output logic        valid,
    output logic        irq
);

    localparam logic [2:0] ACC_WORD   = 3'b011;
    localparam logic [2:0] ACC_DOUBLE = 3'b100;

    localparam logic [2:0] IDX_MTIME    = 3'd0;
    localparam logic [2:0] IDX_MTIMECMP = 3'd1;
    localparam logic [2:0] IDX_CTRL     = 3'd2;
    localparam logic [2:0] IDX_STATUS   = 3'd3;
    localparam logic [2:0] IDX_PRESCALE = 3'd4;

    localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

    logic [63:0]           mtime_q,     mtime_d;
    logic [63:0]           mtimecmp_q,  mtimecmp_d;
    logic [2:0]            ctrl_q,      ctrl_d;
    logic                  pending_q,   pending_d;
    logic [PRESCALE_W-1:0] prescale_q,  prescale_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [63:0]           data_out_q,  data_out_d;
    logic                  valid_q,     valid_d;
    logic                  irq_q,       irq_d;

    logic [63:0] offset;
    logic        in_range;
    logic [2:0]  reg_idx;
    logic        rd_en, wr_en, rd_word, wr_word;
    logic [63:0] reg_full;
    logic [63:0] rd_val;
    logic [63:0] wr_val;
    logic        tick, match, w1c;

    // Word writes replace only the half selected by addr[2].
    function automatic logic [63:0] merge_write(input logic [63:0] old_val,
                                                input logic [63:0] wdata,
                                                input logic        is_word,
                                                input logic        hi);
        if (!is_word)
            return wdata;
        else if (hi)
            return {wdata[31:0], old_val[31:0]};
        else
            return {old_val[63:32], wdata[31:0]};
    endfunction

    // Address decode and register read mux shared by reads and writes.
    always_comb begin
        offset   = addr - BASE_ADDR;
        in_range = (addr >= BASE_ADDR) && (offset < 64'h28);
        reg_idx  = offset[5:3];
        rd_en    = (rd_ctrl == ACC_WORD) || (rd_ctrl == ACC_DOUBLE);
        wr_en    = ((wr_ctrl == ACC_WORD) || (wr_ctrl == ACC_DOUBLE)) && in_range;
        rd_word  = (rd_ctrl == ACC_WORD);
        wr_word  = (wr_ctrl == ACC_WORD);

        reg_full = 64'd0;
        if (in_range) begin
            case (reg_idx)
                IDX_MTIME:    reg_full = mtime_q;
                IDX_MTIMECMP: reg_full = mtimecmp_q;
                IDX_CTRL:     reg_full = {61'd0, ctrl_q};
                IDX_STATUS:   reg_full = {63'd0, pending_q};
                IDX_PRESCALE: reg_full = {{(64-PRESCALE_W){1'b0}}, prescale_q};
                default:      reg_full = 64'd0;
            endcase
        end

        if (!rd_word)
            rd_val = reg_full;
        else if (addr[2])
            rd_val = {32'd0, reg_full[63:32]};
        else
            rd_val = {32'd0, reg_full[31:0]};

        wr_val = merge_write(reg_full, data_in, wr_word, addr[2]);
    end

    // Next-state logic: tick, compare, pending, bus writes with priority.
    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        ctrl_d      = ctrl_q;
        pending_d   = pending_q;
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        tick        = 1'b0;

        if (ctrl_q[0]) begin
            if (presc_cnt_q == prescale_q) begin
                presc_cnt_d = '0;
                tick        = 1'b1;
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_ONE;
            end
        end

        match = (mtime_q >= mtimecmp_q);

        if (tick) begin
            if (ctrl_q[2] && match)
                mtime_d = 64'd0;
            else
                mtime_d = mtime_q + 64'd1;
        end

        // Only a write covering bit 0 of status can clear pending.
        w1c = wr_en && (reg_idx == IDX_STATUS) && !(wr_word && addr[2]) && data_in[0];
        if (w1c)
            pending_d = 1'b0;
        if (match)
            pending_d = 1'b1;

        if (wr_en) begin
            case (reg_idx)
                IDX_MTIME:    mtime_d    = wr_val;
                IDX_MTIMECMP: mtimecmp_d = wr_val;
                IDX_CTRL:     ctrl_d     = wr_val[2:0];
                IDX_PRESCALE: begin
                    prescale_d  = wr_val[PRESCALE_W-1:0];
                    presc_cnt_d = '0;
                end
                default: ;
            endcase
        end

        irq_d      = pending_q & ctrl_q[1];
        valid_d    = rd_en;
        data_out_d = rd_en ? rd_val : data_out_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_q      <= 3'd0;
            pending_q   <= 1'b0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            data_out_q  <= 64'd0;
            valid_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            ctrl_q      <= ctrl_d;
            pending_q   <= pending_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            irq_q       <= irq_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Testbench for bus_timer: constant vector table, directed multi-cycle
// sequences and a random phase checked against a register-level model.
module tb_bus_timer;

    localparam logic [63:0] BASE = 64'h0000_0000_2000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr;
    logic [2:0]  rd_ctrl;
    logic [2:0]  wr_ctrl;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic        valid;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl),
        .data_in(data_in), .data_out(data_out), .valid(valid), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: register file view ----------------
    logic [63:0] m_reg [5];   // 0 mtime, 1 mtimecmp, 2 ctrl, 3 status, 4 prescale
    logic [15:0] m_cnt;
    logic        m_valid, m_irq;
    logic [63:0] m_dout;

    task automatic model_reset();
        m_reg[0] = 64'd0; m_reg[1] = ONES; m_reg[2] = 64'd0;
        m_reg[3] = 64'd0; m_reg[4] = 64'd0;
        m_cnt = 16'd0; m_valid = 1'b0; m_irq = 1'b0; m_dout = 64'd0;
    endtask

    task automatic model_edge(input logic r, input logic [2:0] rc, input logic [2:0] wc,
                              input logic [63:0] a, input logic [63:0] d);
        logic [63:0] old [5];
        logic [63:0] off, full, v;
        logic        hit, rd_ok, wr_ok, tick, match;
        int          idx;
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 5; i++) old[i] = m_reg[i];
        off   = a - BASE;
        hit   = (a >= BASE) && (off < 64'd40);
        idx   = hit ? int'(off[5:3]) : 0;
        full  = hit ? old[idx] : 64'd0;
        rd_ok = (rc == 3'd3) || (rc == 3'd4);
        wr_ok = ((wc == 3'd3) || (wc == 3'd4)) && hit;

        m_irq = old[3][0] && old[2][1];
        tick  = old[2][0] && ({48'd0, m_cnt} == old[4]);
        match = old[0] >= old[1];
        if (old[2][0]) m_cnt = tick ? 16'd0 : m_cnt + 16'd1;
        if (tick) m_reg[0] = (old[2][2] && match) ? 64'd0 : old[0] + 64'd1;
        if (wr_ok && idx == 3 && !(wc == 3'd3 && a[2]) && d[0]) m_reg[3] = 64'd0;
        if (match) m_reg[3] = 64'd1;

        if (wr_ok && idx != 3) begin
            if (wc == 3'd4)  v = d;
            else if (a[2])   v = {d[31:0], old[idx][31:0]};
            else             v = {old[idx][63:32], d[31:0]};
            if (idx == 2) v = v & 64'h7;
            if (idx == 4) begin
                v = v & 64'hFFFF;
                m_cnt = 16'd0;
            end
            m_reg[idx] = v;
        end

        m_valid = rd_ok;
        if (rd_ok) begin
            if (rc == 3'd4)  m_dout = full;
            else if (a[2])   m_dout = full >> 32;
            else             m_dout = full & 64'hFFFF_FFFF;
        end
    endtask

    // ---------------- checking and stimulus helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] rc, input logic [2:0] wc,
                        input logic [63:0] a, input logic [63:0] d);
        rst = r; rd_ctrl = rc; wr_ctrl = wc; addr = a; data_in = d;
        @(posedge clk);
        model_edge(r, rc, wc, a, d);
        @(negedge clk);
        chk("model_valid", 64'(valid), 64'(m_valid));
        chk("model_data_out", data_out, m_dout);
        chk("model_irq", 64'(irq), 64'(m_irq));
    endtask

    task automatic idle();                               step(0, 3'd0, 3'd0, BASE, 64'd0); endtask
    task automatic do_reset();                           step(1, 3'd0, 3'd0, BASE, 64'd0); endtask
    task automatic wr64(input logic [63:0] o, input logic [63:0] d); step(0, 3'd0, 3'd4, BASE + o, d); endtask
    task automatic rd64(input logic [63:0] o);           step(0, 3'd4, 3'd0, BASE + o, 64'd0); endtask

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [63:0] a;
        logic [63:0] d;
        logic        exp_valid;
        logic [63:0] exp_data;
    } vec_t;

    vec_t        vecs [19];
    logic [63:0] addr_pool [13];
    logic [2:0]  code_pool [6];

    initial begin
        bit got;

        vecs[0]  = '{3'd4, 3'd0, BASE + 64'h08, 64'd0,          1'b1, ONES};
        vecs[1]  = '{3'd4, 3'd0, BASE + 64'h00, 64'd0,          1'b1, 64'd0};
        vecs[2]  = '{3'd3, 3'd0, BASE + 64'h0C, 64'd0,          1'b1, 64'hFFFF_FFFF};
        vecs[3]  = '{3'd0, 3'd4, BASE + 64'h20, 64'hABCD_1234,  1'b0, 64'd0};
        vecs[4]  = '{3'd4, 3'd0, BASE + 64'h20, 64'd0,          1'b1, 64'h1234};
        vecs[5]  = '{3'd0, 3'd4, BASE + 64'h10, 64'hFE,         1'b0, 64'd0};
        vecs[6]  = '{3'd4, 3'd0, BASE + 64'h10, 64'd0,          1'b1, 64'd6};
        vecs[7]  = '{3'd4, 3'd0, BASE + 64'h40, 64'd0,          1'b1, 64'd0};
        vecs[8]  = '{3'd0, 3'd3, BASE + 64'h08, 64'h10,         1'b0, 64'd0};
        vecs[9]  = '{3'd4, 3'd0, BASE + 64'h08, 64'd0,          1'b1, 64'hFFFF_FFFF_0000_0010};
        vecs[10] = '{3'd1, 3'd0, BASE + 64'h08, 64'd0,          1'b0, 64'd0};
        vecs[11] = '{3'd4, 3'd0, BASE + 64'h28, 64'd0,          1'b1, 64'd0};
        vecs[12] = '{3'd4, 3'd0, BASE + 64'h18, 64'd0,          1'b1, 64'd0};
        vecs[13] = '{3'd0, 3'd4, BASE + 64'h40, 64'h55,         1'b0, 64'd0};
        vecs[14] = '{3'd4, 3'd0, BASE + 64'h00, 64'd0,          1'b1, 64'd0};
        vecs[15] = '{3'd0, 3'd4, BASE + 64'h00, 64'd5,          1'b0, 64'd0};
        vecs[16] = '{3'd3, 3'd0, BASE + 64'h04, 64'd0,          1'b1, 64'd0};
        vecs[17] = '{3'd3, 3'd0, BASE + 64'h00, 64'd0,          1'b1, 64'd5};
        vecs[18] = '{3'd4, 3'd0, BASE - 64'h08, 64'd0,          1'b1, 64'd0};

        for (int i = 0; i < 10; i++) addr_pool[i] = BASE + 64'(4 * i);
        addr_pool[10] = BASE + 64'h28;
        addr_pool[11] = BASE + 64'h40;
        addr_pool[12] = BASE - 64'h08;
        code_pool = '{3'd0, 3'd0, 3'd3, 3'd4, 3'd1, 3'd7};

        rst = 1'b1; rd_ctrl = 3'd0; wr_ctrl = 3'd0; addr = BASE; data_in = 64'd0;
        model_reset();

        // Reset values.
        do_reset();
        do_reset();
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_data_out", data_out, 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);

        // Vector table: static register behaviour with the counter disabled.
        for (int i = 0; i < 19; i++) begin
            step(0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
        end

        // Prescaled counting, then freeze with enable=0.
        do_reset();
        wr64(64'h20, 64'd3);
        wr64(64'h10, 64'd1);
        for (int i = 0; i < 16; i++) idle();
        rd64(64'h00);
        chk("presc_mtime", data_out, 64'd4);
        wr64(64'h10, 64'd0);
        for (int i = 0; i < 10; i++) idle();
        rd64(64'h00);
        chk("frozen_mtime", data_out, 64'd4);

        // Compare match, irq, W1C priority and clearing.
        do_reset();
        wr64(64'h08, 64'd5);
        wr64(64'h20, 64'd0);
        wr64(64'h10, 64'd3);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            idle();
            if (irq) got = 1'b1;
        end
        chk("irq_rise_within_budget", 64'(got), 64'd1);
        wr64(64'h18, 64'd1);
        rd64(64'h18);
        chk("pending_set_beats_clear", data_out, 64'd1);
        wr64(64'h08, ONES);
        rd64(64'h18);
        chk("cmp_write_keeps_pending", data_out, 64'd1);
        wr64(64'h18, 64'd0);
        rd64(64'h18);
        chk("w0_status_no_effect", data_out, 64'd1);
        wr64(64'h18, 64'd1);
        idle();
        chk("irq_drops_after_w1c", 64'(irq), 64'd0);
        rd64(64'h18);
        chk("pending_cleared", data_out, 64'd0);

        // Auto-reload period of 4.
        do_reset();
        wr64(64'h08, 64'd3);
        wr64(64'h10, 64'd7);
        for (int j = 0; j < 12; j++) begin
            rd64(64'h00);
            chk($sformatf("reload_seq%0d", j), data_out, 64'(j % 4));
        end
        rd64(64'h18);
        chk("reload_pending", data_out, 64'd1);

        // 64-bit wrap and high-word write.
        do_reset();
        wr64(64'h00, 64'hFFFF_FFFF_FFFF_FFFE);
        wr64(64'h10, 64'd1);
        rd64(64'h00);
        chk("wrap_fe", data_out, 64'hFFFF_FFFF_FFFF_FFFE);
        rd64(64'h00);
        chk("wrap_ff", data_out, ONES);
        rd64(64'h00);
        chk("wrap_zero", data_out, 64'd0);
        wr64(64'h10, 64'd0);
        step(0, 3'd0, 3'd3, BASE + 64'h04, 64'h1111_2222_DEAD_BEEF);
        rd64(64'h00);
        chk("word_hi_write", data_out, 64'hDEAD_BEEF_0000_0002);

        // Bus write to mtime beats a tick in the same cycle.
        do_reset();
        wr64(64'h10, 64'd1);
        idle();
        wr64(64'h00, 64'h100);
        rd64(64'h00);
        chk("write_beats_tick", data_out, 64'h100);

        // Reset during a read: no valid, state back to reset values.
        step(1, 3'd4, 3'd0, BASE + 64'h00, 64'd0);
        chk("reset_read_no_valid", 64'(valid), 64'd0);
        rd64(64'h00);
        chk("reset_mtime_zero", data_out, 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic [63:0] a, d;
            logic [2:0]  rc, wc;
            logic        r;
            a  = addr_pool[$urandom_range(0, 12)];
            rc = code_pool[$urandom_range(0, 5)];
            wc = code_pool[$urandom_range(0, 5)];
            d  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) d = 64'($urandom_range(0, 40));
            if (a == BASE + 64'h20) d = 64'($urandom_range(0, 3));
            r  = ($urandom_range(0, 199) == 0);
            step(r, rc, wc, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
